// File: rtl/im_pkg.sv
// im_pkg: shared types and constants for the instruction memory block.
//   im_state_e  - controller phase (clear walk, then normal service)
//   im_rsp_t    - response payload {data, err} at the default 32-bit word width;
//                 im_pipe builds a same-shaped struct at its own DATA_W
//   even_par    - parity bit that makes a byte plus its bit even
package im_pkg;
  localparam int IM_MAX_RD_LAT = 4;
  localparam int IM_BYTE_W     = 8;
  localparam int IM_DATA_W     = 32;

  typedef enum logic [0:0] {IM_INIT, IM_RUN} im_state_e;

  typedef struct packed {
    logic [IM_DATA_W-1:0] data;
    logic                 err;
  } im_rsp_t;

  function automatic logic even_par(input logic [IM_BYTE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/im_rsp_fifo.sv
// im_rsp_fifo: small synchronous FIFO holding read responses in order.
// Ports:
//   clk, rst        clock, async active-high reset (FIFO returns to empty)
//   push_i, data_i  enqueue one entry (ignored while full)
//   pop_i           dequeue head (ignored while empty)
//   data_o          head entry
//   full_o, empty_o occupancy flags
module im_rsp_fifo
  import im_pkg::*;
#(
  parameter type T     = im_rsp_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= (wr_q == LAST) ? '0 : wr_q + PW'(1);
      if (pop_ok)  rd_q <= (rd_q == LAST) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/im_pipe.sv
// im_pipe: word-addressed instruction memory with valid/ready request and
// response channels, RD_LAT-cycle reads, byte-enable writes, out-of-range
// error responses and a zero-fill walk after reset.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_write_i                  1 = write, 0 = read
//   req_addr_i, req_wdata_i      word address, write data
//   req_be_i                     byte enables, bit i -> byte i
//   inj_par_err_i                (IM_PARITY_EN only) invert stored parity on write
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o       read data, error (out of range / parity)
//   init_done_o                  clear walk finished, block in service
// Build option: define IM_PARITY_EN to store one even-parity bit per byte and
// flag mismatches on read.
module im_pipe
  import im_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 65536,
  parameter int RD_LAT   = 1,
  parameter int CLR_INIT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [DATA_W-1:0]           req_wdata_i,
  input  logic [DATA_W/IM_BYTE_W-1:0] req_be_i,
`ifdef IM_PARITY_EN
  input  logic                        inj_par_err_i,
`endif
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        init_done_o
);
  localparam int NB = DATA_W / IM_BYTE_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(RD_LAT + 2);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);
  localparam logic [OW-1:0]   MAX_OUT  = OW'(RD_LAT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef IM_PARITY_EN
  logic [NB-1:0]     par [DEPTH];
`endif

  // ---------------- controller: clear walk then service ----------------
  im_state_e     state_q, state_d;
  logic [IW-1:0] clr_q, clr_d;
  logic          run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IM_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      IM_INIT: begin
        if (CLR_INIT == 0) begin
          state_d = IM_RUN;
        end else if (clr_q == LAST_IDX) begin
          state_d = IM_RUN;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + IW'(1);
        end
      end
      IM_RUN:  state_d = IM_RUN;
      default: state_d = IM_INIT;
    endcase
  end

  assign run         = (state_q == IM_RUN);
  assign init_done_o = run;

  // ---------------- request decode and credit ----------------
  logic          fire, rd_fire, wr_fire, oor, pop, fifo_empty, fifo_full;
  logic [IW-1:0] idx;
  logic [OW-1:0] out_q;
  rsp_t          head;

  assign oor = ({1'b0, req_addr_i} >= DEPTH_A);
  assign idx = req_addr_i[IW-1:0];
  assign pop = ~fifo_empty & rsp_ready_i;

  // Outstanding reads (pipeline + FIFO) never exceed the FIFO depth, so a
  // response can never be dropped; a same-cycle pop frees one credit.
  assign req_ready_o = run & ((out_q < MAX_OUT) | ((out_q == MAX_OUT) & pop));
  assign fire        = req_valid_i & req_ready_o;
  assign rd_fire     = fire & ~req_write_i;
  assign wr_fire     = fire & req_write_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_q + OW'(rd_fire) - OW'(pop);
  end

  // ---------------- array write port (clear walk or byte writes) ----------------
  always_ff @(posedge clk) begin
    if (!run) begin
      if (CLR_INIT != 0) begin
        mem[clr_q] <= '0;
`ifdef IM_PARITY_EN
        par[clr_q] <= '0;
`endif
      end
    end else if (wr_fire && !oor) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be_i[b]) begin
          mem[idx][b*IM_BYTE_W +: IM_BYTE_W] <= req_wdata_i[b*IM_BYTE_W +: IM_BYTE_W];
`ifdef IM_PARITY_EN
          par[idx][b] <= even_par(req_wdata_i[b*IM_BYTE_W +: IM_BYTE_W]) ^ inj_par_err_i;
`endif
        end
      end
    end
  end

  // ---------------- array read, sampled at the acceptance edge ----------------
  rsp_t rd_rsp;

  always_comb begin
    rd_rsp.data = '0;
    rd_rsp.err  = oor;
    if (!oor) begin
      rd_rsp.data = mem[idx];
`ifdef IM_PARITY_EN
      for (int b = 0; b < NB; b++) begin
        if (par[idx][b] != even_par(mem[idx][b*IM_BYTE_W +: IM_BYTE_W])) rd_rsp.err = 1'b1;
      end
`endif
    end
  end

  // ---------------- RD_LAT-1 delay stages into the response FIFO ----------------
  logic push_vld;
  rsp_t push_dat;

  generate
    if (RD_LAT == 1) begin : g_lat1
      // Read result goes straight into the FIFO at the acceptance edge.
      assign push_vld = rd_fire;
      assign push_dat = rd_rsp;
    end else begin : g_latn
      logic [RD_LAT-2:0] vld_pipe_q;
      rsp_t              dat_q [RD_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[0] <= rd_fire;
          for (int k = 1; k < RD_LAT - 1; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_q[0] <= rd_rsp;
        for (int k = 1; k < RD_LAT - 1; k++) dat_q[k] <= dat_q[k-1];
      end

      assign push_vld = vld_pipe_q[RD_LAT-2];
      assign push_dat = dat_q[RD_LAT-2];
    end
  endgenerate

  im_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (RD_LAT + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_vld),
    .data_i  (push_dat),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head is held until popped, so data/err stay stable under backpressure.
  // Outputs read as zero while nothing is pending.
  assign rsp_valid_o = ~fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : head.data;
  assign rsp_err_o   = ~fifo_empty & head.err;
endmodule

// File: tb/tb_im_pipe.sv
module tb_im_pipe;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_write = 0, rsp_ready = 0, inj = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          req_ready, rsp_valid, rsp_err, init_done;
  logic [DW-1:0] rsp_rdata;

  im_pipe #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT), .CLR_INIT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
`ifdef IM_PARITY_EN
    .inj_par_err_i(inj),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .init_done_o(init_done)
  );

  int errors = 0, checks = 0, tcyc = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) tcyc++;

  // ---------------- behavioural model ----------------
  // Memory as a plain array; every accepted read becomes a queue entry stamped
  // with its acceptance cycle and becomes visible LAT cycles later, in order.
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            t;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] mm   [DEPTH];
  logic [NB-1:0] pbad [DEPTH];
  int            init_left = DEPTH;
  int            now = 0;

  function automatic bit m_run();
    return init_left == 0;
  endfunction

  function automatic bit m_valid();
    return q.size() > 0 && now >= q[0].t + LAT;
  endfunction

  function automatic bit m_ready();
    bit p;
    p = m_valid() && rsp_ready;
    return m_run() && (q.size() < LAT + 1 || (q.size() == LAT + 1 && p));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      init_left = DEPTH;
      now = 0;
    end else begin
      bit   p, acc;
      ent_t e;
      p   = m_valid() && rsp_ready;
      acc = req_valid && m_ready();
      if (p) void'(q.pop_front());
      if (acc) begin
        if (req_write) begin
          if (req_addr < DEPTH)
            for (int b = 0; b < NB; b++)
              if (req_be[b]) begin
                mm[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                pbad[req_addr][b] = inj;
              end
        end else begin
          e.err  = (req_addr >= DEPTH);
          e.data = e.err ? '0 : mm[req_addr];
          if (!e.err && |pbad[req_addr]) e.err = 1'b1;
          e.t = now;
          q.push_back(e);
        end
      end
      now++;
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0)
          for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            pbad[i] = '0;
          end
      end
    end
  end

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_init_done", init_done, 0);
      end else begin
        chk("req_ready", req_ready, m_ready());
        chk("rsp_valid", rsp_valid, m_valid());
        chk("init_done", init_done, m_run());
        if (m_valid()) begin
          chk("rsp_rdata", rsp_rdata, q[0].data);
          chk("rsp_err", rsp_err, q[0].err);
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] be, input bit ij, output int acc_t);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_be = be; inj = ij;
    acc_t = -1;
    for (int i = 0; i < 50 && acc_t < 0; i++) begin
      #1;
      if (req_ready === 1'b1) begin
        @(negedge clk);
        acc_t = tcyc;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 0; inj = 0;
    if (acc_t < 0) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] ed, input bit ee,
                          input string nm);
    int at, lat;
    rsp_ready = 1;
    do_req(0, a, '0, '0, 0, at);
    lat = -1;
    if (at >= 0) begin
      for (int i = 0; i < 20 && lat < 0; i++) begin
        #1;
        if (rsp_valid === 1'b1) begin
          lat = tcyc - at + 1;
          chk({nm, "_data"}, rsp_rdata, ed);
          chk({nm, "_err"}, rsp_err, ee);
        end
        @(negedge clk);
      end
      chk({nm, "_latency"}, lat, LAT);
    end
  endtask

  task automatic init_len_chk(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready === 1'b1) break;
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk(nm, n, DEPTH);
    chk({nm, "_done"}, init_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at, acc, nxt, r, gaps, nv;
    rsp_ready = 1;
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    // 1: clear walk length, then all words read back zero
    init_len_chk("init_len");
    for (int i = 0; i < DEPTH; i++) read_chk(AW'(i), 32'h0, 0, "clr_read");

    // 2: byte-enable merge, read right after write, be=0 no-op
    do_req(1, 8'd5, 32'hDEADBEEF, 4'b1111, 0, at);
    do_req(1, 8'd5, 32'h0000AA00, 4'b0010, 0, at);
    read_chk(8'd5, 32'hDEADAAEF, 0, "be_merge");
    do_req(1, 8'd5, 32'hFFFFFFFF, 4'b0000, 0, at);
    read_chk(8'd5, 32'hDEADAAEF, 0, "be_zero");

    // 3: backpressure holds exactly LAT+1 reads, then in-order gap-free stream
    for (int i = 0; i < 8; i++) do_req(1, AW'(i), 32'hA0000000 + i, 4'hF, 0, at);
    rsp_ready = 0;
    acc = 0; nxt = 0; r = 0; gaps = 0;
    for (int c = 0; c < 70 && r < 8; c++) begin
      if (c == 10) begin
        chk("stall_accepted", acc, LAT + 1);
        rsp_ready = 1;
      end
      req_valid = (nxt < 8); req_write = 0; req_addr = AW'(nxt);
      #1;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        chk("stream_order", rsp_rdata, 32'hA0000000 + r);
        r++;
      end else if (r > 0 && r < 8) begin
        gaps++;
      end
      if (req_valid && req_ready === 1'b1) begin
        acc++;
        nxt++;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("stream_count", r, 8);
    chk("stream_gaps", gaps, 0);

    // 4: out-of-range read and dropped write
    do_req(1, 8'd4, 32'h12345678, 4'hF, 0, at);
    read_chk(8'd20, 32'h0, 1, "oor_read");
    read_chk(8'd16, 32'h0, 1, "oor_edge");
    read_chk(8'd15, 32'h0, 0, "last_word");
    do_req(1, 8'd20, 32'hFFFFFFFF, 4'hF, 0, at);
    read_chk(8'd4, 32'h12345678, 0, "oor_write_drop");

    // 5a: reset in the middle of the clear walk restarts it
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk); rst = 0;
    repeat (7) @(negedge clk);
    #1 rst = 1;
    #2 chk("mid_init_ready", req_ready, 0);
    @(negedge clk); rst = 0;
    init_len_chk("reinit_len");
    read_chk(8'd4, 32'h0, 0, "reinit_clear");

    // 5b: reset with two reads outstanding leaves nothing behind
    rsp_ready = 0;
    do_req(0, 8'd1, '0, '0, 0, at);
    do_req(0, 8'd2, '0, '0, 0, at);
    #1 rst = 1;
    #1 chk("rst_kills_valid", rsp_valid, 0);
    @(negedge clk); rst = 0; rsp_ready = 1;
    init_len_chk("post_rst_len");
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (rsp_valid === 1'b1) nv++;
      @(negedge clk);
    end
    chk("no_stale_rsp", nv, 0);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom % 3) != 0;
      req_write = ($urandom % 4) == 0;
      req_addr  = AW'($urandom % 20);
      req_wdata = $urandom;
      req_be    = NB'($urandom % 16);
      rsp_ready = ($urandom % 4) != 0;
`ifdef IM_PARITY_EN
      inj = ($urandom % 8) == 0;
`endif
      @(negedge clk);
    end
    req_valid = 0; inj = 0; rsp_ready = 1;
    repeat (10) @(negedge clk);

`ifdef IM_PARITY_EN
    // 6: injected parity error and recovery by rewrite
    do_req(1, 8'd3, 32'h00000055, 4'hF, 0, at);
    do_req(1, 8'd3, 32'h00000077, 4'b0001, 1, at);
    read_chk(8'd3, 32'h00000077, 1, "par_inject");
    do_req(1, 8'd3, 32'h00000077, 4'b0001, 0, at);
    read_chk(8'd3, 32'h00000077, 0, "par_clean");
`endif

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
